// File: rtl/hex_render_pkg.sv
// Shared font geometry and FSM state type for the hex line renderer.
package hex_render_pkg;

    localparam int FONT_W = 5;
    localparam int FONT_H = 5;
    localparam int CELL_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/hex_cell_counter.sv
// sub/col/dig cascade for the horizontal walk; outputs describe the pixel of the
// current cycle, with i_start forcing position zero so the first box pixel needs no lead-in.
module hex_cell_counter
    import hex_render_pkg::*;
#(
    parameter int NDIGITS    = 4,
    parameter int SCALE_LOG2 = 1,
    parameter int SUB_W      = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1,
    parameter int DIG_W      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_run,
    output logic [2:0]       o_col,
    output logic [DIG_W-1:0] o_dig,
    output logic             o_last
);

    localparam logic [SUB_W-1:0] SUB_MAX       = SUB_W'((32'd1 << SCALE_LOG2) - 32'd1);
    localparam logic [2:0]       COL_GAP       = 3'(CELL_W - 1);
    localparam logic [2:0]       COL_FONT_LAST = 3'(FONT_W - 1);
    localparam logic [DIG_W-1:0] DIG_LAST      = DIG_W'(NDIGITS - 1);

    logic [SUB_W-1:0] r_sub;
    logic [2:0]       r_col;
    logic [DIG_W-1:0] r_dig;
    logic [SUB_W-1:0] w_sub;
    logic [2:0]       w_col;
    logic [DIG_W-1:0] w_dig;
    logic [SUB_W-1:0] w_sub_nx;
    logic [2:0]       w_col_nx;
    logic [DIG_W-1:0] w_dig_nx;
    logic             w_sub_wrap;

    // Current position and its successor in the sub -> col -> dig cascade.
    always_comb begin
        w_sub      = i_start ? {SUB_W{1'b0}} : r_sub;
        w_col      = i_start ? 3'd0 : r_col;
        w_dig      = i_start ? {DIG_W{1'b0}} : r_dig;
        w_sub_wrap = (w_sub == SUB_MAX);
        w_sub_nx   = w_sub_wrap ? {SUB_W{1'b0}} : (w_sub + {{(SUB_W-1){1'b0}}, 1'b1});
        w_col_nx   = w_col;
        w_dig_nx   = w_dig;
        if (w_sub_wrap) begin
            if (w_col == COL_GAP) begin
                w_col_nx = 3'd0;
                w_dig_nx = w_dig + {{(DIG_W-1){1'b0}}, 1'b1};
            end else begin
                w_col_nx = w_col + 3'd1;
            end
        end else begin
            w_col_nx = w_col;
        end
    end

    // Counter state advances only on cycles that render a box pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= {SUB_W{1'b0}};
            r_col <= 3'd0;
            r_dig <= {DIG_W{1'b0}};
        end else if (i_run) begin
            r_sub <= w_sub_nx;
            r_col <= w_col_nx;
            r_dig <= w_dig_nx;
        end else begin
            r_sub <= r_sub;
            r_col <= r_col;
            r_dig <= r_dig;
        end
    end

    assign o_col  = w_col;
    assign o_dig  = w_dig;
    assign o_last = (w_dig == DIG_LAST) && (w_col == COL_FONT_LAST) && w_sub_wrap;

endmodule

// File: rtl/hex_line_render.sv
// Draws NDIGITS hex digits at (X0, Y0) through an external 5x5 char generator,
// with a per-frame shadow of the value and a fixed two-cycle pixel latency.
module hex_line_render
    import hex_render_pkg::*;
#(
    parameter int NDIGITS    = 4,
    parameter int X0         = 16,
    parameter int Y0         = 16,
    parameter int SCALE_LOG2 = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic                   de,
    output logic [3:0]             digit,
    output logic [2:0]             yoff,
    input  logic [4:0]             bits,
    output logic                   pix,
    output logic                   de_out
);

    localparam int               VAL_W    = 4 * NDIGITS;
    localparam int               DIG_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [10:0]      Y0_W     = 11'(Y0);
    localparam logic [10:0]      ROW_SPAN = 11'(FONT_H << SCALE_LOG2);
    localparam logic [9:0]       X0_W     = 10'(X0);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NDIGITS - 1);

    state_e             r_state;
    state_e             w_state_nx;
    logic [VAL_W-1:0]   r_shadow;
    logic [3:0]         r_digit;
    logic [2:0]         r_yoff;
    logic               r_hit1;
    logic [2:0]         r_col1;
    logic               r_de1;
    logic               r_pix;
    logic               r_de_out;

    logic [10:0]        w_ry;
    logic               w_row_hit;
    logic [2:0]         w_yoff;
    logic               w_start;
    logic               w_run_now;
    logic [2:0]         w_col;
    logic [DIG_W-1:0]   w_dig;
    logic               w_last;
    logic [DIG_W+1:0]   w_nib_base;
    logic [3:0]         w_nibble;
    logic               w_font_bit;

    // Unsigned subtraction: rows above Y0 wrap to a large value and fail the span test.
    assign w_ry      = {1'b0, vpos} - Y0_W;
    assign w_row_hit = ({1'b0, vpos} >= Y0_W) && (w_ry < ROW_SPAN);
    assign w_yoff    = 3'(w_ry >> SCALE_LOG2);

    // hpos == X0 restarts the walk even mid-run, so a line wrap without blanking is handled.
    assign w_start   = de && w_row_hit && (hpos == X0_W);
    assign w_run_now = w_start || ((r_state == RUN) && de);

    hex_cell_counter #(
        .NDIGITS    (NDIGITS),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_cell_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_run   (w_run_now),
        .o_col   (w_col),
        .o_dig   (w_dig),
        .o_last  (w_last)
    );

    // Next state: stay in RUN until the last font column of the last digit or a de drop.
    always_comb begin
        w_state_nx = IDLE;
        if (w_run_now && !w_last) begin
            w_state_nx = RUN;
        end else begin
            w_state_nx = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Per-frame shadow of the displayed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= {VAL_W{1'b0}};
        end else if (frame_start) begin
            r_shadow <= value;
        end else begin
            r_shadow <= r_shadow;
        end
    end

    // Leftmost digit is the most significant nibble.
    assign w_nib_base = {DIG_LAST - w_dig, 2'b00};
    assign w_nibble   = r_shadow[w_nib_base +: 4];

    // Stage 1: char generator address plus the gating needed one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
            r_yoff  <= 3'd0;
            r_hit1  <= 1'b0;
            r_col1  <= 3'd0;
            r_de1   <= 1'b0;
        end else begin
            if (w_run_now) begin
                r_digit <= w_nibble;
                r_yoff  <= w_yoff;
            end else begin
                r_digit <= r_digit;
                r_yoff  <= r_yoff;
            end
            r_hit1 <= w_run_now && (w_col < 3'(FONT_W));
            r_col1 <= w_col;
            r_de1  <= de;
        end
    end

    // Font column select; the gap column never lights.
    always_comb begin
        w_font_bit = 1'b0;
        case (r_col1)
            3'd0:    w_font_bit = bits[0];
            3'd1:    w_font_bit = bits[1];
            3'd2:    w_font_bit = bits[2];
            3'd3:    w_font_bit = bits[3];
            3'd4:    w_font_bit = bits[4];
            default: w_font_bit = 1'b0;
        endcase
    end

    // Stage 2: final pixel and aligned display enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix    <= 1'b0;
            r_de_out <= 1'b0;
        end else begin
            r_pix    <= r_de1 && r_hit1 && w_font_bit;
            r_de_out <= r_de1;
        end
    end

    assign digit  = r_digit;
    assign yoff   = r_yoff;
    assign pix    = r_pix;
    assign de_out = r_de_out;

endmodule
